// File: rtl/filter_pkg.sv
// Shared definitions for the second-order recursive filter and its feeder.
// Sample width, coefficients and feeder FSM encoding live here.
package filter_pkg;

    localparam int DATA_W = 32;

    // y = a^2*y[n-2] + a*b*x[n-1] + b*x[n]
    localparam int COEF_A = 2;
    localparam int COEF_B = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } feed_state_t;

endpackage

// File: rtl/filter_sample_fifo.sv
// Small synchronous FIFO buffering samples ahead of the filter feeder.
// No bypass: a pushed word becomes visible at head on the next edge.
module filter_sample_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              push,
    input  logic [DATA_W-1:0] data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Full blocks a push even if a pop happens in the same cycle.
    assign do_push = push && !full && !clear;
    assign do_pop  = pop && !empty && !clear;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= data;
    end

endmodule

// File: rtl/filter_sample_feeder.sv
// Feeds x[n] and x[n-1] to the recursive filter, one sample per hold
// period, and freezes the multiplier pipeline when the FIFO runs dry.
module filter_sample_feeder
    import filter_pkg::*;
#(
    parameter int DATA_W      = filter_pkg::DATA_W,
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              run,
    input  logic              flush,
    output logic [DATA_W-1:0] x_n,
    output logic [DATA_W-1:0] x_n_1,
    output logic              enable_start,
    output logic              sample_strobe,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count
);

    localparam int HC_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    feed_state_t       state;
    feed_state_t       state_nx;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_nx;
    logic              do_load;
    logic              do_flush;

    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    logic [DATA_W-1:0] x_nx;
    logic [DATA_W-1:0] x1_nx;
    logic              en_nx;
    logic              strobe_nx;
    logic [CNT_W-1:0]  cnt_nx;

    assign in_ready = !fifo_full;

    filter_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (do_flush),
        .push  (in_valid),
        .data  (in_data),
        .pop   (do_load),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            hold_cnt <= '0;
        end else begin
            state    <= state_nx;
            hold_cnt <= hold_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        do_load  = 1'b0;
        do_flush = 1'b0;
        unique case (state)
            IDLE: begin
                if (flush)
                    do_flush = 1'b1;
                else if (run)
                    state_nx = LOAD;
            end
            LOAD: begin
                // Dropping run wins over a waiting sample.
                if (!run) begin
                    state_nx = IDLE;
                end else if (!fifo_empty) begin
                    do_load = 1'b1;
                    if (HOLD_CYCLES > 1) begin
                        state_nx = HOLD;
                        hold_nx  = HC_W'(HOLD_CYCLES - 1);
                    end
                end
            end
            HOLD: begin
                if (hold_cnt <= HC_W'(1)) begin
                    state_nx = LOAD;
                    hold_nx  = '0;
                end else begin
                    hold_nx = hold_cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                hold_nx  = '0;
            end
        endcase
    end

    always_comb begin
        x_nx      = x_n;
        x1_nx     = x_n_1;
        en_nx     = enable_start;
        strobe_nx = 1'b0;
        cnt_nx    = sample_count;
        if (do_flush) begin
            x_nx   = '0;
            x1_nx  = '0;
            cnt_nx = '0;
        end else if (do_load) begin
            x1_nx     = x_n;
            x_nx      = fifo_head;
            en_nx     = 1'b1;
            strobe_nx = 1'b1;
            cnt_nx    = sample_count + 1'b1;
        end else if (state == LOAD) begin
            en_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_n           <= '0;
            x_n_1         <= '0;
            enable_start  <= 1'b0;
            sample_strobe <= 1'b0;
            sample_count  <= '0;
            busy          <= 1'b0;
        end else begin
            x_n           <= x_nx;
            x_n_1         <= x1_nx;
            enable_start  <= en_nx;
            sample_strobe <= strobe_nx;
            sample_count  <= cnt_nx;
            busy          <= (state_nx != IDLE);
        end
    end

endmodule

// File: tb/tb_filter_sample_feeder.sv
// Scoreboard bench for filter_sample_feeder: delivered samples are
// compared in order against the words the bench pushed.
module tb_filter_sample_feeder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        run = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] x_n;
    logic [31:0] x_n_1;
    logic        enable_start;
    logic        sample_strobe;
    logic        busy;
    logic [3:0]  sample_count;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    logic [31:0] prev_exp = '0;
    logic [3:0]  exp_cnt = '0;
    int          strobes = 0;
    int          cyc = 0;
    int          strobe_cyc[$];

    filter_sample_feeder #(
        .DATA_W      (32),
        .DEPTH       (4),
        .HOLD_CYCLES (2),
        .CNT_W       (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .run           (run),
        .flush         (flush),
        .x_n           (x_n),
        .x_n_1         (x_n_1),
        .enable_start  (enable_start),
        .sample_strobe (sample_strobe),
        .busy          (busy),
        .sample_count  (sample_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && sample_strobe) begin
            strobes++;
            strobe_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = sb.pop_front();
                chk("x_n", x_n, e);
                chk("x_n_1", x_n_1, prev_exp);
                prev_exp = e;
                exp_cnt  = exp_cnt + 4'd1;
                chk("count", 32'(sample_count), 32'(exp_cnt));
            end
        end
    end

    task automatic do_push(input logic [31:0] w, output bit acc);
        @(negedge clk);
        in_data  = w;
        in_valid = 1'b1;
        acc      = in_ready;
        if (acc) sb.push_back(w);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) do_push(w, ok);
        if (!ok) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_strobe();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = sample_strobe;
        end
        if (!seen) chk("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = (sb.size() == 0);
        end
        if (!done) chk("drain_timeout", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_x_n"}, x_n, 32'd0);
        chk({tag, "_x_n_1"}, x_n_1, 32'd0);
        chk({tag, "_en"}, 32'(enable_start), 32'd0);
        chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_cnt"}, 32'(sample_count), 32'd0);
    endtask

    initial begin
        bit acc;
        int n0;

        // power-on reset
        repeat (3) @(negedge clk);
        chk_reset_state("por");
        chk("por_strobe", 32'(sample_strobe), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // reset in the middle of a hold with words queued
        for (int i = 0; i < 4; i++) push_word(32'hA0 + 32'(i));
        @(negedge clk);
        run = 1'b1;
        wait_strobe();
        #1;
        reset = 1'b0;
        #1;
        chk_reset_state("rst_in");
        sb.delete();
        prev_exp = '0;
        exp_cnt  = '0;
        run      = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_state("rst_out");

        // streaming 5, 7, 9
        @(negedge clk);
        run = 1'b1;
        strobe_cyc.delete();
        push_word(32'd5);
        push_word(32'd7);
        push_word(32'd9);
        wait_drain();
        repeat (4) @(negedge clk);
        chk("stream_strobes", 32'(strobe_cyc.size()), 32'd3);
        if (strobe_cyc.size() == 3) begin
            chk("gap1", 32'(strobe_cyc[1] - strobe_cyc[0]), 32'd2);
            chk("gap2", 32'(strobe_cyc[2] - strobe_cyc[1]), 32'd2);
        end
        chk("stream_cnt", 32'(sample_count), 32'd3);
        chk("stream_en_off", 32'(enable_start), 32'd0);

        // back-pressure with a full FIFO
        run = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_push(32'h40 + 32'(i), acc);
            chk("bp_acc", 32'(acc), 32'd1);
        end
        @(negedge clk);
        chk("bp_full", 32'(in_ready), 32'd0);
        do_push(32'hDEAD, acc);
        chk("bp_reject", 32'(acc), 32'd0);
        @(negedge clk);
        run = 1'b1;
        wait_strobe();
        @(negedge clk);
        chk("bp_ready", 32'(in_ready), 32'd1);
        wait_drain();

        // underflow gap freezes the filter
        push_word(32'd11);
        wait_strobe();
        repeat (4) @(negedge clk);
        chk("uf_en", 32'(enable_start), 32'd0);
        chk("uf_hold", x_n, 32'd11);
        repeat (6) @(negedge clk);
        chk("uf_en2", 32'(enable_start), 32'd0);
        push_word(32'd13);
        wait_drain();

        // dropping run mid-hold lets the hold finish
        run = 1'b0;
        repeat (3) @(negedge clk);
        push_word(32'd21);
        push_word(32'd23);
        @(negedge clk);
        run = 1'b1;
        wait_strobe();
        run = 1'b0;
        @(negedge clk);
        chk("stop_busy1", 32'(busy), 32'd1);
        @(negedge clk);
        chk("stop_busy2", 32'(busy), 32'd1);
        chk("stop_en2", 32'(enable_start), 32'd1);
        @(negedge clk);
        chk("stop_busy3", 32'(busy), 32'd0);
        chk("stop_en3", 32'(enable_start), 32'd0);
        chk("stop_x", x_n, 32'd21);

        // flush during a hold is ignored
        run = 1'b1;
        wait_strobe();
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("hflush_x", x_n, 32'd23);
        chk("hflush_x1", x_n_1, 32'd21);
        chk("hflush_cnt", 32'(sample_count), 32'(exp_cnt));
        run = 1'b0;
        repeat (3) @(negedge clk);

        // flush in idle clears everything, queued word included
        push_word(32'd31);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        sb.delete();
        prev_exp = '0;
        exp_cnt  = '0;
        @(negedge clk);
        chk("flush_x", x_n, 32'd0);
        chk("flush_x1", x_n_1, 32'd0);
        chk("flush_cnt", 32'(sample_count), 32'd0);
        n0 = strobes;
        run = 1'b1;
        repeat (8) @(negedge clk);
        chk("flush_empty", 32'(strobes), 32'(n0));
        chk("flush_en", 32'(enable_start), 32'd0);

        // counter wrap with a 4-bit count
        for (int i = 0; i < 17; i++) push_word(32'h100 + 32'(i));
        wait_drain();
        repeat (3) @(negedge clk);
        chk("wrap_cnt", 32'(sample_count), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
